bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Synthesizable target-side end of the CPU bus (ce/rd/wr/addr/data_wr/data_rd). It decodes single read and write transfers from the initiator into a local memory array. It inserts a programmable number of wait states, acknowledges each transfer with a one-cycle `ready` pulse, and flags illegal transfers on `err`. It sits between the CPU bus and on-chip storage and replaces the behavioural memory model used in bus benches.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `DEPTH`, 256: implemented words; addresses ≥ DEPTH are out of range.
- `WAIT_CYCLES`, 1: wait states inserted before acknowledge (0..15).
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ce` in 1: chip enable; the transfer is valid while high.
- `rd` in 1: read strobe.
- `wr` in 1: write strobe.
- `addr` in ADDR_W: transfer address.
- `data_wr` in DATA_W: write data.
- `data_rd` out DATA_W: read data, valid while `ready`=1.
- `ready` out 1: one-cycle transfer acknowledge.
- `err` out 1: one-cycle error acknowledge, coincident with `ready`.

## Operation
- FSM states: IDLE, WAIT, ACK, DONE.
- IDLE:
  - A request is `ce`=1 and (`rd` or `wr`) at a posedge.
  - The block latches `addr`, `data_wr` and the op.
  - It goes to WAIT with counter = WAIT_CYCLES−1, or straight to ACK if WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each cycle; at 0 the FSM goes to ACK.
  - If `ce` drops, the transfer aborts: return to IDLE, no write, no `ready`.
- ACK (one cycle):
  - `ready`=1.
  - Write: mem[latched addr] ← latched data.
  - Read: `data_rd` ← mem[latched addr].
  - Next state is DONE.
- DONE:
  - Outputs are idle.
  - The FSM stays until `ce`=0, then goes to IDLE, so a held request is never serviced twice.
- Error cases: `rd`&`wr` both high, or latched addr ≥ DEPTH.
  - ACK still occurs with `ready`=1 and `err`=1.
  - No memory write; `data_rd` = 0.
- `data_rd` holds its last value after ACK until the next read ACK or reset.
- Signals are sampled only in IDLE. Changes to `addr`/`data_wr` during WAIT are ignored.
- Memory contents are not cleared by reset; reads of never-written locations are undefined (X in sim).

## Timing
- Reset values: `ready`=0, `err`=0, `data_rd`=0, state=IDLE, counter=0.
- Request sampled at posedge N → `ready` high during cycle N+WAIT_CYCLES+1.
  - Default WAIT_CYCLES=1: `ready` arrives 2 cycles after the request edge.
- Write data is visible to a read whose request is sampled at or after the ACK edge + 2 (earliest legal next request, after DONE/IDLE).
- Minimum transfer spacing is WAIT_CYCLES+3 cycles, including one cycle of `ce`=0.
- `ready`/`err` are registered outputs with no combinational path from inputs.
- `rst_n` asserted mid-transfer:
  - Immediate return to IDLE and outputs cleared.
  - A pending write is dropped; memory is otherwise unchanged.
- `ce` dropping in the same cycle as ACK: ACK completes normally, then DONE → IDLE next cycle.

## Structure
- Shared package `bus_pkg`:
  - State enum (IDLE/WAIT/ACK/DONE).
  - Op encoding (OP_RD, OP_WR, OP_BAD).
  - Default ADDR_W/DATA_W constants.
- Sub-module `bus_wait_counter`: loadable down-counter with a `zero` flag, 4 bits.
- Memory is an inferred register array inside `bus_mem_responder`.
- Estimated 150–250 lines of RTL.

## Test plan
- Write 0x11←0xAA, then read 0x11: `ready` at request+2 both times, `data_rd`=0xAA, `err`=0.
- WAIT_CYCLES=0: write 0x12←0xAB then read 0x12 → `ready` at request+1, `data_rd`=0xAB.
- `rd`=`wr`=1 at addr 0x13 → `ready`=`err`=1, `data_rd`=0x00, mem[0x13] unchanged (check with a prior write of 0x0A and a later read returning 0x0A).
- DEPTH=16, read 0x20 → `err`=1, `data_rd`=0; write 0x20 does not alias into mem[0x00].
- WAIT_CYCLES=3, `ce` held high for 10 cycles on one write → exactly one `ready` pulse; dropping `ce` during WAIT → no `ready`, memory unchanged.
- `rst_n` pulsed low during WAIT of a write to 0x05 → outputs 0 immediately, mem[0x05] keeps its old value, next transfer works normally.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the CPU-bus memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_ADDR_W_DEFAULT = 8;
    localparam int c_DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_BAD = 2'd2
    } op_t;

    // Simultaneous read and write strobes are an illegal transfer.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr)
            return OP_BAD;
        else if (wr)
            return OP_WR;
        else
            return OP_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_wait_counter
// Description : 4-bit loadable down-counter with a zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 4'd0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec)
            r_count <= r_count - 4'd1;
    end

    assign o_zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder
// Description : CPU-bus target with wait states, ready/err acknowledge and a
//               local register-array memory.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEFAULT,
    parameter int DATA_W      = c_DATA_W_DEFAULT,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_wr,
    output logic [DATA_W-1:0] data_rd,
    output logic              ready,
    output logic              err
);

    localparam int         c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT_LD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         c_NO_WAIT  = (WAIT_CYCLES == 0);

    state_t              r_state;
    op_t                 r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data_rd;
    logic                r_ready;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req;
    logic                w_zero;
    logic                w_load;
    logic                w_dec;
    logic                w_go_ack;
    op_t                 w_act_op;
    logic [ADDR_W-1:0]   w_act_addr;
    logic [DATA_W-1:0]   w_act_wdata;
    logic                w_act_bad;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_mem_we;

    assign w_req  = ce && (rd || wr);
    assign w_load = (r_state == IDLE) && w_req;
    assign w_dec  = (r_state == WAIT) && ce && !w_zero;

    // With no wait states the acknowledge is taken straight from the live
    // request, so the transfer attributes bypass the latches in IDLE.
    assign w_go_ack    = ((r_state == IDLE) && w_req && c_NO_WAIT) ||
                         ((r_state == WAIT) && ce && w_zero);
    assign w_act_op    = (r_state == IDLE) ? decode_op(rd, wr) : r_op;
    assign w_act_addr  = (r_state == IDLE) ? addr : r_addr;
    assign w_act_wdata = (r_state == IDLE) ? data_wr : r_wdata;
    assign w_act_bad   = (w_act_op == OP_BAD) || (32'(w_act_addr) >= DEPTH);
    assign w_idx       = w_act_addr[c_IDX_W-1:0];
    assign w_mem_we    = w_go_ack && (w_act_op == OP_WR) && !w_act_bad;

    bus_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (c_WAIT_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_idx] <= w_act_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_RD;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data_rd <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            if (w_go_ack) begin
                r_ready <= 1'b1;
                r_err   <= w_act_bad;
                if (w_act_bad)
                    r_data_rd <= '0;
                else if (w_act_op == OP_RD)
                    r_data_rd <= r_mem[w_idx];
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op    <= decode_op(rd, wr);
                        r_addr  <= addr;
                        r_wdata <= data_wr;
                        r_state <= c_NO_WAIT ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!ce)
                        r_state <= IDLE;
                    else if (w_zero)
                        r_state <= ACK;
                end
                ACK:     r_state <= DONE;
                // Hold here until ce drops so a held request is serviced once.
                DONE:    if (!ce) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_rd = r_data_rd;
    assign ready   = r_ready;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Directed self-checking bench over three parameterisations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

    logic            clk = 1'b0;
    logic [2:0]      rst_n;
    logic [2:0]      ce;
    logic [2:0]      rd;
    logic [2:0]      wr;
    logic [2:0][7:0] addr;
    logic [2:0][7:0] dwr;
    wire  [2:0]      rdy;
    wire  [2:0]      er;
    wire  [7:0]      q0;
    wire  [7:0]      q1;
    wire  [7:0]      q2;

    int n_assert = 0;
    int n_fail   = 0;

    int          lat;
    logic        e_got;
    logic [7:0]  q_got;
    logic        extra;
    int          pulses;

    always #5 clk = ~clk;

    // Index 0: defaults; 1: no wait states; 2: three wait states, 16 words.
    bus_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n[0]), .ce(ce[0]), .rd(rd[0]), .wr(wr[0]),
        .addr(addr[0]), .data_wr(dwr[0]), .data_rd(q0), .ready(rdy[0]), .err(er[0])
    );
    bus_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n[1]), .ce(ce[1]), .rd(rd[1]), .wr(wr[1]),
        .addr(addr[1]), .data_wr(dwr[1]), .data_rd(q1), .ready(rdy[1]), .err(er[1])
    );
    bus_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .rst_n(rst_n[2]), .ce(ce[2]), .rd(rd[2]), .wr(wr[2]),
        .addr(addr[2]), .data_wr(dwr[2]), .data_rd(q2), .ready(rdy[2]), .err(er[2])
    );

    function automatic logic [7:0] qsel(input int d);
        case (d)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: request held until ready (bounded), kept one
    // more cycle to expose any repeated pulse, then ce dropped.
    task automatic xfer(input int d, input logic r_i, input logic w_i,
                        input logic [7:0] a, input logic [7:0] wd,
                        output int l, output logic e, output logic [7:0] q,
                        output logic x);
        @(negedge clk);
        ce[d] = 1'b1; rd[d] = r_i; wr[d] = w_i; addr[d] = a; dwr[d] = wd;
        l = 0; e = 1'bx; q = 8'hxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                l = i; e = er[d]; q = qsel(d);
                break;
            end
        end
        @(negedge clk);
        x = rdy[d];
        ce[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'hC3; dwr[d] = 8'h3C;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 3'b000; ce = '0; rd = '0; wr = '0; addr = '0; dwr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_err",   32'(er),  32'h0);
        chk("rst_data",  32'({q0, q1, q2}), 32'h0);
        rst_n = 3'b111;

        // Default timing: write then read back
        xfer(0, 1'b0, 1'b1, 8'h11, 8'hAA, lat, e_got, q_got, extra);
        chk("d1_wr_lat", 32'(lat), 32'd2);
        chk("d1_wr_err", 32'(e_got), 32'd0);
        chk("d1_wr_single", 32'(extra), 32'd0);
        xfer(0, 1'b1, 1'b0, 8'h11, 8'h00, lat, e_got, q_got, extra);
        chk("d1_rd_lat", 32'(lat), 32'd2);
        chk("d1_rd_data", 32'(q_got), 32'hAA);
        chk("d1_rd_err", 32'(e_got), 32'd0);

        // rd & wr together: error, memory untouched
        xfer(0, 1'b0, 1'b1, 8'h13, 8'h0A, lat, e_got, q_got, extra);
        xfer(0, 1'b1, 1'b1, 8'h13, 8'h55, lat, e_got, q_got, extra);
        chk("d1_bad_lat", 32'(lat), 32'd2);
        chk("d1_bad_err", 32'(e_got), 32'd1);
        chk("d1_bad_data", 32'(q_got), 32'h00);
        xfer(0, 1'b1, 1'b0, 8'h13, 8'h00, lat, e_got, q_got, extra);
        chk("d1_bad_keep", 32'(q_got), 32'h0A);
        chk("d1_bad_keep_err", 32'(e_got), 32'd0);

        // No wait states
        xfer(1, 1'b0, 1'b1, 8'h12, 8'hAB, lat, e_got, q_got, extra);
        chk("d0_wr_lat", 32'(lat), 32'd1);
        xfer(1, 1'b1, 1'b0, 8'h12, 8'h00, lat, e_got, q_got, extra);
        chk("d0_rd_lat", 32'(lat), 32'd1);
        chk("d0_rd_data", 32'(q_got), 32'hAB);
        chk("d0_rd_single", 32'(extra), 32'd0);

        // DEPTH=16: out-of-range accesses error and do not alias
        xfer(2, 1'b0, 1'b1, 8'h00, 8'h5C, lat, e_got, q_got, extra);
        chk("d3_wr_lat", 32'(lat), 32'd4);
        xfer(2, 1'b1, 1'b0, 8'h20, 8'h00, lat, e_got, q_got, extra);
        chk("d3_oor_rd_err", 32'(e_got), 32'd1);
        chk("d3_oor_rd_data", 32'(q_got), 32'h00);
        xfer(2, 1'b0, 1'b1, 8'h20, 8'hFF, lat, e_got, q_got, extra);
        chk("d3_oor_wr_err", 32'(e_got), 32'd1);
        xfer(2, 1'b1, 1'b0, 8'h00, 8'h00, lat, e_got, q_got, extra);
        chk("d3_no_alias", 32'(q_got), 32'h5C);
        chk("d3_no_alias_err", 32'(e_got), 32'd0);

        // ce held 10 cycles on one write: exactly one ready pulse
        @(negedge clk);
        ce[2] = 1'b1; wr[2] = 1'b1; addr[2] = 8'h03; dwr[2] = 8'h77;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[2]) pulses++;
        end
        ce[2] = 1'b0; wr[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("d3_held_pulses", 32'(pulses), 32'd1);

        // ce dropped during WAIT: abort, no ready, memory unchanged
        ce[2] = 1'b1; wr[2] = 1'b1; addr[2] = 8'h03; dwr[2] = 8'h99;
        repeat (2) @(negedge clk);
        ce[2] = 1'b0; wr[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy[2]) pulses++;
        end
        chk("d3_abort_pulses", 32'(pulses), 32'd0);
        xfer(2, 1'b1, 1'b0, 8'h03, 8'h00, lat, e_got, q_got, extra);
        chk("d3_abort_mem", 32'(q_got), 32'h77);

        // data_rd holds across a write ACK
        xfer(0, 1'b0, 1'b1, 8'h05, 8'h21, lat, e_got, q_got, extra);
        chk("d1_hold_data", 32'(q_got), 32'h0A);

        // Reset pulsed during WAIT of a write to 0x05
        xfer(0, 1'b1, 1'b0, 8'h11, 8'h00, lat, e_got, q_got, extra);
        @(negedge clk);
        ce[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h05; dwr[0] = 8'hEE;
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk("d1_rst_data", 32'(q0), 32'h00);
        chk("d1_rst_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        chk("d1_rst_ready2", 32'(rdy[0]), 32'd0);
        chk("d1_rst_err", 32'(er[0]), 32'd0);
        ce[0] = 1'b0; wr[0] = 1'b0;
        rst_n[0] = 1'b1;
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 8'h05, 8'h00, lat, e_got, q_got, extra);
        chk("d1_post_rst_lat", 32'(lat), 32'd2);
        chk("d1_post_rst_mem", 32'(q_got), 32'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
